// File: rtl/flght_cmd_pkg.sv
// Shared opcodes, response codes and sequencer state for the flight command sequencer.
package flght_cmd_pkg;

  localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
  localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
  localparam logic [7:0] CMD_SET_YAW   = 8'h04;
  localparam logic [7:0] CMD_SET_THRST = 8'h05;
  localparam logic [7:0] CMD_CALIBRATE = 8'h06;
  localparam logic [7:0] CMD_EMER_LAND = 8'h07;
  localparam logic [7:0] CMD_MTRS_OFF  = 8'h08;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  typedef enum logic [1:0] {IDLE, RAMP, CAL} seq_state_e;

  typedef struct packed {
    logic [15:0] ptch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic [8:0]  thrst;
  } setpt_t;

endpackage

// File: rtl/flght_cmd_seq_sat_cntr.sv
// Saturating up-counter with synchronous clear; full flags the all-ones value.
module sat_cntr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         full
);

  logic [W-1:0] cnt_q, cnt_d;

  assign full = &cnt_q;
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)              cnt_d = '0;
    else if (en && !full) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/flght_cmd_seq.sv
// Command sequencer: setpoint registers, spin-up/calibration handshake and
// command-loss landing in front of the flight controller.
module flght_cmd_seq
  import flght_cmd_pkg::*;
#(
  parameter int RAMP_W = 9,
  parameter int TMO_W  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        cal_done,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic [7:0]  resp,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst,
  output logic        inertial_cal,
  output logic        strt_cal,
  output logic        motors_off
);

  // One below all-ones: lets registered pulses line up with the counter reaching full.
  localparam logic [RAMP_W-1:0] RAMP_PRE = {{(RAMP_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0]  TMO_PRE  = {{(TMO_W-1){1'b1}}, 1'b0};

  seq_state_e  state_q, state_d;
  setpt_t      sp_q, sp_d;
  logic        moff_q, moff_d;
  logic        ical_q, ical_d;
  logic        strt_q, strt_d;
  logic        clr_q, clr_d;
  logic        sresp_q, sresp_d;
  logic [7:0]  resp_q, resp_d;

  logic [RAMP_W-1:0] ramp_cnt;
  logic              ramp_full;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_full;
  logic              accept, tmo_en, tmo_clr, tmo_fire;

  // The cycle that carries clr_cmd_rdy still sees the old cmd_rdy level.
  assign accept   = (state_q == IDLE) && cmd_rdy && !clr_q;
  assign tmo_en   = (state_q == IDLE) && !cmd_rdy && !tmo_full;
  assign tmo_clr  = accept || (state_q != IDLE);
  assign tmo_fire = tmo_en && (tmo_cnt == TMO_PRE);

  sat_cntr #(.W(RAMP_W)) u_ramp_cntr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != RAMP),
    .en    (state_q == RAMP),
    .cnt   (ramp_cnt),
    .full  (ramp_full)
  );

  sat_cntr #(.W(TMO_W)) u_tmo_cntr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .cnt   (tmo_cnt),
    .full  (tmo_full)
  );

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    moff_d  = moff_q;
    ical_d  = ical_q;
    strt_d  = 1'b0;
    clr_d   = 1'b0;
    sresp_d = 1'b0;
    resp_d  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          clr_d   = 1'b1;
          sresp_d = 1'b1;
          resp_d  = RESP_ACK;
          case (cmd)
            CMD_SET_PTCH:  sp_d.ptch  = data;
            CMD_SET_ROLL:  sp_d.roll  = data;
            CMD_SET_YAW:   sp_d.yaw   = data;
            CMD_SET_THRST: sp_d.thrst = data[8:0];
            CMD_CALIBRATE: begin
              // Acknowledged only once calibration completes.
              sresp_d = 1'b0;
              resp_d  = '0;
              moff_d  = 1'b0;
              ical_d  = 1'b1;
              state_d = RAMP;
            end
            CMD_EMER_LAND: sp_d = '0;
            CMD_MTRS_OFF: begin
              moff_d     = 1'b1;
              sp_d.thrst = '0;
            end
            default: resp_d = RESP_NAK;
          endcase
        end else if (tmo_fire) begin
          sp_d = '0;
        end
      end
      RAMP: begin
        strt_d = (ramp_cnt == RAMP_PRE);
        if (ramp_full) state_d = CAL;
      end
      CAL: begin
        if (cal_done) begin
          ical_d  = 1'b0;
          sresp_d = 1'b1;
          resp_d  = RESP_ACK;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sp_q    <= '0;
      moff_q  <= 1'b1;
      ical_q  <= 1'b0;
      strt_q  <= 1'b0;
      clr_q   <= 1'b0;
      sresp_q <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      moff_q  <= moff_d;
      ical_q  <= ical_d;
      strt_q  <= strt_d;
      clr_q   <= clr_d;
      sresp_q <= sresp_d;
      resp_q  <= resp_d;
    end
  end

  assign clr_cmd_rdy  = clr_q;
  assign send_resp    = sresp_q;
  assign resp         = resp_q;
  assign d_ptch       = sp_q.ptch;
  assign d_roll       = sp_q.roll;
  assign d_yaw        = sp_q.yaw;
  assign thrst        = sp_q.thrst;
  assign inertial_cal = ical_q;
  assign strt_cal     = strt_q;
  assign motors_off   = moff_q;

endmodule

// File: tb/tb_flght_cmd_seq.sv
// Self-checking bench for flght_cmd_seq: vector table, hand sequences for the
// calibration/timeout/reset corners, and randomized commands against a transaction model.
module tb_flght_cmd_seq;
  import flght_cmd_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, cmd_rdy = 1'b0, cal_done = 1'b0;
  logic [7:0]  cmd = '0;
  logic [15:0] data = '0;
  logic        clr_cmd_rdy, send_resp, inertial_cal, strt_cal, motors_off;
  logic [7:0]  resp;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;

  int total = 0, bad = 0;

  // transaction-level model
  logic [15:0] m_ptch = '0, m_roll = '0, m_yaw = '0;
  logic [8:0]  m_thr = '0;
  logic        m_moff = 1'b1;
  int          m_idle = 0;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] dt;
    logic [7:0]  rsp;
    logic [15:0] p, r, y;
    logic [8:0]  t;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  flght_cmd_seq #(.RAMP_W(4), .TMO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst),
    .inertial_cal(inertial_cal), .strt_cal(strt_cal), .motors_off(motors_off)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_ptch"}, 64'(d_ptch), 64'(m_ptch));
    chk({tag, "_roll"}, 64'(d_roll), 64'(m_roll));
    chk({tag, "_yaw"},  64'(d_yaw),  64'(m_yaw));
    chk({tag, "_thr"},  64'(thrst),  64'(m_thr));
    chk({tag, "_moff"}, 64'(motors_off), 64'(m_moff));
  endtask

  // Idle cycles in IDLE with no command; 31 consecutive ones land the craft.
  task automatic idle(input int g);
    bit sr = 1'b0;
    for (int i = 0; i < g; i++) begin
      step();
      if (send_resp) sr = 1'b1;
      m_idle++;
      if (m_idle == 31) begin
        m_ptch = '0; m_roll = '0; m_yaw = '0; m_thr = '0;
      end
    end
    if (g > 0) chk("no_resp_idle", 64'(sr), 64'(0));
  endtask

  // Returns in the cycle after acceptance with cmd_rdy already dropped.
  task automatic issue(input logic [7:0] op, input logic [15:0] dt, output bit ok);
    int n = 0;
    cmd = op; data = dt; cmd_rdy = 1'b1;
    do begin step(); n++; end while (!clr_cmd_rdy && n < 200);
    ok = clr_cmd_rdy;
    cmd_rdy = 1'b0;
    m_idle = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL accept_timeout: op %0h never consumed, want clr_cmd_rdy", op); end
  endtask

  function automatic logic [7:0] mexec(input logic [7:0] op, input logic [15:0] dt);
    case (op)
      8'h02: m_ptch = dt;
      8'h03: m_roll = dt;
      8'h04: m_yaw  = dt;
      8'h05: m_thr  = dt[8:0];
      8'h07: begin m_ptch = '0; m_roll = '0; m_yaw = '0; m_thr = '0; end
      8'h08: begin m_moff = 1'b1; m_thr = '0; end
      default: return 8'hEE;
    endcase
    return 8'hA5;
  endfunction

  initial begin
    bit ok, anyclr, sr;
    int first, sel, g;
    logic [7:0] op, er;
    logic [15:0] dt;

    tbl[0]  = '{8'h03, 16'h1234, 8'hA5, 16'hFF38, 16'h1234, 16'h0000, 9'h000};
    tbl[1]  = '{8'h04, 16'h8001, 8'hA5, 16'hFF38, 16'h1234, 16'h8001, 9'h000};
    tbl[2]  = '{8'h05, 16'hFFFF, 8'hA5, 16'hFF38, 16'h1234, 16'h8001, 9'h1FF};
    tbl[3]  = '{8'h3C, 16'h5555, 8'hEE, 16'hFF38, 16'h1234, 16'h8001, 9'h1FF};
    tbl[4]  = '{8'h07, 16'h0000, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000};
    tbl[5]  = '{8'h05, 16'h0064, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h064};
    tbl[6]  = '{8'h02, 16'h7FFF, 8'hA5, 16'h7FFF, 16'h0000, 16'h0000, 9'h064};
    tbl[7]  = '{8'h08, 16'h0000, 8'hA5, 16'h7FFF, 16'h0000, 16'h0000, 9'h000};
    tbl[8]  = '{8'h00, 16'hFFFF, 8'hEE, 16'h7FFF, 16'h0000, 16'h0000, 9'h000};
    tbl[9]  = '{8'h05, 16'hFE03, 8'hA5, 16'h7FFF, 16'h0000, 16'h0000, 9'h003};
    tbl[10] = '{8'h09, 16'h1111, 8'hEE, 16'h7FFF, 16'h0000, 16'h0000, 9'h003};

    // reset state
    step(); step();
    chk("rst_clr", 64'(clr_cmd_rdy), 64'(0));
    chk("rst_sresp", 64'(send_resp), 64'(0));
    chk("rst_resp", 64'(resp), 64'(0));
    chk("rst_ical", 64'(inertial_cal), 64'(0));
    chk("rst_strt", 64'(strt_cal), 64'(0));
    chk_regs("rst");
    @(negedge clk); rst_n = 1'b1;
    step();

    // SET_PTCH with cmd_rdy held one extra cycle
    cmd = CMD_SET_PTCH; data = 16'hFF38; cmd_rdy = 1'b1;
    step();
    chk("ptch_clr", 64'(clr_cmd_rdy), 64'(1));
    chk("ptch_sresp", 64'(send_resp), 64'(1));
    chk("ptch_resp", 64'(resp), 64'(8'hA5));
    chk("ptch_val", 64'(d_ptch), 64'(16'hFF38));
    step();
    chk("no_reaccept_clr", 64'(clr_cmd_rdy), 64'(0));
    chk("pulse_end_sresp", 64'(send_resp), 64'(0));
    chk("pulse_end_resp", 64'(resp), 64'(0));
    cmd_rdy = 1'b0;
    step();
    chk("no_reaccept_late", 64'(clr_cmd_rdy), 64'(0));

    // vector table
    for (int i = 0; i < 11; i++) begin
      idle(2);
      issue(tbl[i].op, tbl[i].dt, ok);
      chk("tbl_sresp", 64'(send_resp), 64'(1));
      chk("tbl_resp", 64'(resp), 64'(tbl[i].rsp));
      chk("tbl_ptch", 64'(d_ptch), 64'(tbl[i].p));
      chk("tbl_roll", 64'(d_roll), 64'(tbl[i].r));
      chk("tbl_yaw", 64'(d_yaw), 64'(tbl[i].y));
      chk("tbl_thr", 64'(thrst), 64'(tbl[i].t));
      chk("tbl_moff", 64'(motors_off), 64'(1));
    end
    m_ptch = 16'h7FFF; m_roll = '0; m_yaw = '0; m_thr = 9'h003; m_moff = 1'b1;

    // command-loss timeout: 30 idle cycles hold, the 31st lands
    idle(2);
    issue(CMD_SET_THRST, 16'd100, ok);
    er = mexec(CMD_SET_THRST, 16'd100);
    chk("tmo_resp", 64'(resp), 64'(er));
    idle(30);
    chk_regs("tmo30");
    chk("tmo30_thr_abs", 64'(thrst), 64'(100));
    idle(1);
    chk_regs("tmo31");
    chk("tmo31_thr_abs", 64'(thrst), 64'(0));
    idle(5);
    issue(CMD_SET_THRST, 16'h000A, ok);
    er = mexec(CMD_SET_THRST, 16'h000A);
    chk("post_tmo_sresp", 64'(send_resp), 64'(1));
    chk("post_tmo_resp", 64'(resp), 64'(er));
    chk_regs("post_tmo");

    // calibration with a SET_YAW waiting behind it
    idle(2);
    issue(CMD_CALIBRATE, 16'h0000, ok);
    m_moff = 1'b0;
    chk("cal_ical", 64'(inertial_cal), 64'(1));
    chk("cal_moff", 64'(motors_off), 64'(0));
    chk("cal_no_resp", 64'(send_resp), 64'(0));
    chk("cal_strt_early", 64'(strt_cal), 64'(0));
    cmd = CMD_SET_YAW; data = 16'h0BAD; cmd_rdy = 1'b1;
    first = -1; anyclr = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      step();
      if (clr_cmd_rdy) anyclr = 1'b1;
      if (strt_cal && first < 0) first = i;
    end
    chk("strt_cycle", 64'(first), 64'(16));
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    chk("strt_one_cycle", 64'(strt_cal), 64'(0));
    chk("cal_done_ignored", 64'(send_resp), 64'(0));
    chk("cal_ical_hold", 64'(inertial_cal), 64'(1));
    step(); step();
    if (clr_cmd_rdy) anyclr = 1'b1;
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    chk("cal_ack_sresp", 64'(send_resp), 64'(1));
    chk("cal_ack_resp", 64'(resp), 64'(8'hA5));
    chk("cal_ack_ical", 64'(inertial_cal), 64'(0));
    chk("yaw_still_pending", 64'(clr_cmd_rdy | anyclr), 64'(0));
    step();
    cmd_rdy = 1'b0;
    m_idle = 0;
    er = mexec(CMD_SET_YAW, 16'h0BAD);
    chk("yaw_clr", 64'(clr_cmd_rdy), 64'(1));
    chk("yaw_resp", 64'(resp), 64'(er));
    chk_regs("yaw");

    // randomized commands against the model
    for (int it = 0; it < 120; it++) begin
      sel = $urandom_range(0, 7);
      dt  = 16'($urandom);
      case (sel)
        0: op = CMD_SET_PTCH;
        1: op = CMD_SET_ROLL;
        2: op = CMD_SET_YAW;
        3, 4: op = CMD_SET_THRST;
        5: op = CMD_EMER_LAND;
        6: op = CMD_MTRS_OFF;
        default: begin
          op = 8'($urandom_range(0, 255));
          if (op >= 8'h02 && op <= 8'h08) op = 8'h3C;
        end
      endcase
      g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(25, 40)) : int'($urandom_range(0, 4));
      idle(g);
      er = mexec(op, dt);
      issue(op, dt, ok);
      chk("rnd_sresp", 64'(send_resp), 64'(1));
      chk("rnd_resp", 64'(resp), 64'(er));
      chk_regs("rnd");
    end

    // asynchronous reset in CAL abandons the calibration
    idle(1);
    issue(CMD_SET_THRST, 16'h0155, ok);
    issue(CMD_CALIBRATE, 16'h0000, ok);
    for (int i = 0; i < 18; i++) step();
    chk("pre_rst_ical", 64'(inertial_cal), 64'(1));
    chk("pre_rst_thr", 64'(thrst), 64'(9'h155));
    #2 rst_n = 1'b0;
    #1;
    m_ptch = '0; m_roll = '0; m_yaw = '0; m_thr = '0; m_moff = 1'b1;
    chk("arst_ical", 64'(inertial_cal), 64'(0));
    chk_regs("arst");
    @(negedge clk); rst_n = 1'b1;
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    sr = send_resp;
    for (int i = 0; i < 4; i++) begin step(); if (send_resp) sr = 1'b1; end
    chk("arst_no_ack", 64'(sr), 64'(0));
    chk("arst_ical_low", 64'(inertial_cal), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flght_cmd_seq.md
# flght_cmd_seq

Command sequencer and setpoint configuration block in front of `flght_cntrl`. It consumes decoded 8-bit commands with 16-bit data from the comm link and holds the `d_ptch`/`d_roll`/`d_yaw`/`thrst` setpoints. It sequences the motor spin-up and inertial calibration handshake, and forces an emergency landing on command loss. Every consumed command gets a response byte.

## Interface
- `RAMP_W`, default 9: motor spin-up wait is 2^RAMP_W cycles.
- `TMO_W`, default 10: command-loss timeout is 2^TMO_W − 1 idle cycles.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_rdy` in 1: a command/data pair is valid; held until cleared.
- `cmd` in 8: command opcode.
- `data` in 16: command operand.
- `cal_done` in 1: inertial calibration complete (1-cycle pulse).
- `clr_cmd_rdy` out 1: 1-cycle pulse; the command is consumed.
- `send_resp` out 1: 1-cycle pulse; `resp` is valid.
- `resp` out 8: response byte.
- `d_ptch`, `d_roll`, `d_yaw` out 16 each: signed setpoints.
- `thrst` out 9: unsigned thrust.
- `inertial_cal` out 1: high throughout spin-up and calibration.
- `strt_cal` out 1: 1-cycle pulse that starts calibration.
- `motors_off` out 1: motors disabled.

## Operation
- Reset values:
  - all setpoints, `thrst`, `resp`, and all pulses are 0.
  - `inertial_cal` is 0.
  - `motors_off` is 1.
  - state is IDLE and both counters are 0.
- Opcodes:
  - 0x02 SET_PTCH, 0x03 SET_ROLL, 0x04 SET_YAW: load `data[15:0]` into the matching setpoint.
  - 0x05 SET_THRST: load `thrst` from `data[8:0]`; `data[15:9]` is ignored.
  - 0x06 CALIBRATE: start the calibration sequence below.
  - 0x07 EMER_LAND: zero all three setpoints and `thrst`.
  - 0x08 MTRS_OFF: set `motors_off` to 1 and zero `thrst`.
- Responses:
  - Every command except CALIBRATE gets an immediate ACK, 0xA5.
  - An unknown opcode gets NAK, 0xEE, and changes no state.
- FSM state IDLE:
  - `cmd_rdy` high: execute the opcode, then pulse `clr_cmd_rdy` and `send_resp`.
  - CALIBRATE additionally clears `motors_off`, sets `inertial_cal` to 1, clears the ramp counter, and moves to RAMP. It does not send a response at this point.
- FSM state RAMP:
  - The ramp counter increments every cycle.
  - On reaching 2^RAMP_W − 1, pulse `strt_cal` and move to CAL.
- FSM state CAL:
  - Wait for `cal_done`.
  - On `cal_done`, clear `inertial_cal`, send ACK, and return to IDLE.
- `cmd_rdy` in RAMP or CAL is not consumed: `clr_cmd_rdy` stays low and the command is serviced after the return to IDLE.
- Command-loss timeout:
  - The timeout counter increments each IDLE cycle in which `cmd_rdy` is low.
  - It clears whenever a command is consumed, and is held at 0 in RAMP and CAL.
  - When it reaches all-ones, zero the setpoints and `thrst` (no response), then saturate.
  - It leaves saturation only when the next command is consumed.
- An asynchronous reset asserted mid-sequence returns every output and the state to reset values immediately; a pending calibration is abandoned.

## Timing
- Command accepted in cycle N, i.e. `cmd_rdy` sampled high at the edge ending cycle N:
  - the setpoint register updates at that edge;
  - `clr_cmd_rdy`, `send_resp` and `resp` are valid during cycle N+1 only.
- All outputs are registered; there are no combinational input-to-output paths.
- `cmd_rdy` still high during cycle N+1, before the source drops it, must not be re-accepted. Suppress acceptance in any cycle in which `clr_cmd_rdy` is high.
- CALIBRATE accepted in cycle N:
  - `inertial_cal` is high from cycle N+1.
  - `strt_cal` pulses in cycle N+1+(2^RAMP_W − 1).
  - `cal_done` seen at the edge ending cycle M: `send_resp` with ACK and `inertial_cal` low both appear in cycle M+1.
- `cal_done` arriving in the same cycle as `strt_cal` is ignored; the CAL state is entered on the following edge.
- A timeout and a command accepted in the same cycle: the command wins and the counter clears.

## Structure
- Package `flght_cmd_pkg` holds:
  - opcode localparams CMD_SET_PTCH through CMD_MTRS_OFF;
  - RESP_ACK = 8'hA5 and RESP_NAK = 8'hEE;
  - state enum {IDLE, RAMP, CAL}.
- Sub-module `sat_cntr`: parameterised width, `clr`/`en` inputs, `full` flag, saturating. It is instantiated twice, once for the ramp counter and once for the timeout counter.

## Test plan
- Reset, then SET_PTCH with data 0xFF38 → `d_ptch` = −200 one edge after acceptance. `clr_cmd_rdy`, `send_resp` and `resp` = 0xA5 each high for exactly one cycle. `cmd_rdy` held high for a second cycle is not double-accepted.
- SET_THRST with data 0xFFFF → `thrst` = 0x1FF. Then EMER_LAND → all setpoints and `thrst` are 0, with ACK.
- CALIBRATE, RAMP_W = 4 → `motors_off` falls and `inertial_cal` rises in cycle N+1. `strt_cal` pulses in cycle N+16. A SET_YAW issued during RAMP is not consumed until after the ACK that follows `cal_done`.
- Opcode 0x3C → `resp` = 0xEE and no register changes.
- TMO_W = 5 with no commands after a SET_THRST of 100 → `thrst` is 0 after 31 idle cycles, with no `send_resp`. The next command is accepted normally.
- `rst_n` pulsed low in CAL → `inertial_cal` 0, `motors_off` 1, and no ACK.
